branch_flag_unit: RTL and testbench

- Consumer side of the ALU result/flag interface: latches fZero/fSign/fCarry from ALU flag-setting instructions and resolves KGP-RISC branches (b, bl, br, bcy, bncy, bz, bnz, bltz) against them.
- Issues a registered PC redirect to the fetch stage over a valid/ready handshake, requests the link write for bl, and holds a post-redirect flush window.
- Sits between the ALU and the fetch/PC logic.

---
 rtl/branch_flag_unit_if.sv | 42 ++++
 rtl/branch_flag_unit.sv | 139 +++++++++++++
 tb/tb_branch_flag_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_flag_unit_if.sv
// Bundle between the ALU/decode side, the branch/flag unit and fetch.
// master: the side that presents ALU results, branches and fetch-ready.
// slave:  the branch/flag unit itself.
interface branch_flag_unit_if #(
    parameter int CNT_W = 16
);
    // ALU result/flag side
    logic              alu_valid;
    logic              flag_we;
    logic [31:0]       alu_result;
    logic              alu_fZero;
    logic              alu_fSign;
    logic              alu_fCarry;
    // branch presentation
    logic              br_valid;
    logic [2:0]        br_type;
    logic [31:0]       br_target;
    logic [31:0]       br_reg;
    logic [31:0]       pc_plus4;
    // fetch redirect handshake
    logic              redirect_ready;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    // link write, stall and status
    logic              link_we;
    logic [31:0]       link_data;
    logic              busy;
    logic [2:0]        flags;
    logic [CNT_W-1:0]  taken_count;

    modport master (
        output alu_valid, flag_we, alu_result, alu_fZero, alu_fSign, alu_fCarry,
        output br_valid, br_type, br_target, br_reg, pc_plus4, redirect_ready,
        input  redirect_valid, redirect_pc, link_we, link_data, busy, flags, taken_count
    );

    modport slave (
        input  alu_valid, flag_we, alu_result, alu_fZero, alu_fSign, alu_fCarry,
        input  br_valid, br_type, br_target, br_reg, pc_plus4, redirect_ready,
        output redirect_valid, redirect_pc, link_we, link_data, busy, flags, taken_count
    );
endinterface

// File: rtl/branch_flag_unit.sv
// Branch/flag unit: latches ALU flags, resolves KGP-RISC branches against
// them and issues a registered PC redirect followed by a flush window.
// Optional macro FLAG_BYPASS_EN: a flag-setting ALU op and a branch in the
// same idle cycle resolve against the incoming ALU values instead of the
// flag register.
module branch_flag_unit #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    branch_flag_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    localparam logic [2:0] BR_B    = 3'b000;
    localparam logic [2:0] BR_BL   = 3'b001;
    localparam logic [2:0] BR_BCY  = 3'b010;
    localparam logic [2:0] BR_BNCY = 3'b011;
    localparam logic [2:0] BR_BZ   = 3'b100;
    localparam logic [2:0] BR_BNZ  = 3'b101;
    localparam logic [2:0] BR_BLTZ = 3'b110;

    state_t     state;
    logic [2:0] flush_cnt;
    logic       flag_upd;
    logic       cond_zero;
    logic       cond_sign;
    logic       cond_carry;
    logic       taken;

    // A flag write is only honoured while the unit is not stalling upstream.
    always_comb flag_upd = bus.alu_valid & bus.flag_we & ~bus.busy;

`ifdef FLAG_BYPASS_EN
    // Same-cycle flag-setting op: resolve against the live ALU outputs.
    always_comb begin
        cond_zero  = bus.flags[0];
        cond_sign  = bus.flags[1];
        cond_carry = bus.flags[2];
        if (flag_upd && bus.br_valid) begin
            cond_zero  = (bus.alu_result == 32'd0);
            cond_sign  = bus.alu_result[31];
            cond_carry = bus.alu_fCarry;
        end
    end
`else
    // Branches always see the flag register as it was before this edge.
    always_comb begin
        cond_zero  = bus.flags[0];
        cond_sign  = bus.flags[1];
        cond_carry = bus.flags[2];
    end

    logic unused_alu_result;
    assign unused_alu_result = ^bus.alu_result;
`endif

    // Branch condition decode.
    always_comb begin
        taken = 1'b1;
        case (bus.br_type)
            BR_B, BR_BL: taken = 1'b1;
            BR_BCY:      taken = cond_carry;
            BR_BNCY:     taken = ~cond_carry;
            BR_BZ:       taken = cond_zero;
            BR_BNZ:      taken = ~cond_zero;
            BR_BLTZ:     taken = cond_sign;
            default:     taken = 1'b1;   // br
        endcase
    end

    // Control FSM with registered outputs, flag register and taken counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            flush_cnt          <= 3'd0;
            bus.flags          <= 3'b000;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= 32'd0;
            bus.link_we        <= 1'b0;
            bus.link_data      <= 32'd0;
            bus.busy           <= 1'b0;
            bus.taken_count    <= '0;
        end else begin
            bus.link_we <= 1'b0;
            if (flag_upd) begin
                bus.flags <= {bus.alu_fCarry, bus.alu_fSign, bus.alu_fZero};
            end
            case (state)
                IDLE: begin
                    if (bus.br_valid && taken) begin
                        state              <= REDIRECT;
                        bus.redirect_valid <= 1'b1;
                        bus.busy           <= 1'b1;
                        bus.redirect_pc    <= (bus.br_type == 3'b111) ? bus.br_reg : bus.br_target;
                        if (bus.br_type == BR_BL) begin
                            bus.link_we   <= 1'b1;
                            bus.link_data <= bus.pc_plus4;
                        end
                        if (bus.taken_count != CNT_MAX) begin
                            bus.taken_count <= bus.taken_count + CNT_ONE;
                        end
                    end
                end
                REDIRECT: begin
                    if (bus.redirect_ready) begin
                        state              <= FLUSH;
                        bus.redirect_valid <= 1'b0;
                        flush_cnt          <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (flush_cnt <= 3'd1) begin
                        state     <= IDLE;
                        bus.busy  <= 1'b0;
                        flush_cnt <= 3'd0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state              <= IDLE;
                    bus.redirect_valid <= 1'b0;
                    bus.busy           <= 1'b0;
                    flush_cnt          <= 3'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed testbench for branch_flag_unit (small counter to reach saturation).
module tb_branch_flag_unit;
    localparam int FC = 3;
    localparam int CW = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_cnt;

    branch_flag_unit_if #(.CNT_W(CW)) bus ();

    branch_flag_unit #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.alu_valid      = 1'b0;
        bus.flag_we        = 1'b0;
        bus.alu_result     = 32'd0;
        bus.alu_fZero      = 1'b0;
        bus.alu_fSign      = 1'b0;
        bus.alu_fCarry     = 1'b0;
        bus.br_valid       = 1'b0;
        bus.br_type        = 3'b000;
        bus.br_target      = 32'd0;
        bus.br_reg         = 32'd0;
        bus.pc_plus4       = 32'd0;
        bus.redirect_ready = 1'b0;
    endtask

    task automatic alu_op(input logic [31:0] res, input logic z, input logic s, input logic c);
        bus.alu_valid  = 1'b1;
        bus.flag_we    = 1'b1;
        bus.alu_result = res;
        bus.alu_fZero  = z;
        bus.alu_fSign  = s;
        bus.alu_fCarry = c;
        step();
        bus.alu_valid  = 1'b0;
        bus.flag_we    = 1'b0;
    endtask

    task automatic branch(input logic [2:0] t, input logic [31:0] tgt,
                          input logic [31:0] rg, input logic [31:0] pc4);
        bus.br_valid  = 1'b1;
        bus.br_type   = t;
        bus.br_target = tgt;
        bus.br_reg    = rg;
        bus.pc_plus4  = pc4;
        step();
        bus.br_valid  = 1'b0;
    endtask

    // Accept the pending redirect and wait (bounded) for the flush to end.
    task automatic drain(input string tag);
        bus.redirect_ready = 1'b1;
        for (int i = 0; i < 20 && bus.busy; i++) step();
        bus.redirect_ready = 1'b0;
        check(tag, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // reset state
        check("rst_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check("rst_pc",    bus.redirect_pc, 32'd0);
        check("rst_link",  {31'd0, bus.link_we}, 32'd0);
        check("rst_ldata", bus.link_data, 32'd0);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_flags", {29'd0, bus.flags}, 32'd0);
        check("rst_cnt",   {28'd0, bus.taken_count}, 32'd0);

        // async reset in the middle of REDIRECT
        branch(3'b000, 32'h40, 32'h0, 32'h0);
        check("b40_valid", {31'd0, bus.redirect_valid}, 32'd1);
        check("b40_pc",    bus.redirect_pc, 32'h40);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check("arst_pc",    bus.redirect_pc, 32'd0);
        check("arst_busy",  {31'd0, bus.busy}, 32'd0);
        check("arst_cnt",   {28'd0, bus.taken_count}, 32'd0);
        #1 rst = 1'b0;
        step();
        branch(3'b100, 32'h300, 32'h0, 32'h0);
        check("bz_nt_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check("bz_nt_busy",  {31'd0, bus.busy}, 32'd0);

        // 12+10 -> Z=0, then bnz taken, ready held low 3 cycles
        alu_op(32'd22, 1'b0, 1'b0, 1'b0);
        check("add_flags", {29'd0, bus.flags}, 32'd0);
        branch(3'b101, 32'h100, 32'h0, 32'h0);
        exp_cnt = 1;
        check("bnz_valid", {31'd0, bus.redirect_valid}, 32'd1);
        check("bnz_pc",    bus.redirect_pc, 32'h100);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bnz_hold_pc",    bus.redirect_pc, 32'h100);
            check("bnz_hold_busy",  {31'd0, bus.busy}, 32'd1);
            check("bnz_hold_valid", {31'd0, bus.redirect_valid}, 32'd1);
        end
        bus.redirect_ready = 1'b1;
        step();
        bus.redirect_ready = 1'b0;
        check("bnz_hs_valid", {31'd0, bus.redirect_valid}, 32'd0);
        for (int i = 0; i < FC; i++) begin
            check("flush_busy", {31'd0, bus.busy}, 32'd1);
            step();
        end
        check("flush_done", {31'd0, bus.busy}, 32'd0);
        check("cnt_1", {28'd0, bus.taken_count}, exp_cnt);

        // 8 xor 8 -> Z=1; bz taken; then bcy with C=0 not taken
        alu_op(32'd0, 1'b1, 1'b0, 1'b0);
        check("xor_flags", {29'd0, bus.flags}, 32'h1);
        branch(3'b100, 32'h200, 32'h0, 32'h0);
        exp_cnt++;
        check("bz_valid", {31'd0, bus.redirect_valid}, 32'd1);
        check("bz_pc",    bus.redirect_pc, 32'h200);
        drain("bz_drain");
        branch(3'b010, 32'h300, 32'h0, 32'h0);
        check("bcy_nt_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check("bcy_nt_busy",  {31'd0, bus.busy}, 32'd0);
        check("cnt_2", {28'd0, bus.taken_count}, exp_cnt);

        // bl: one-cycle link write
        branch(3'b001, 32'h80, 32'h0, 32'h24);
        exp_cnt++;
        check("bl_link",  {31'd0, bus.link_we}, 32'd1);
        check("bl_ldata", bus.link_data, 32'h24);
        check("bl_pc",    bus.redirect_pc, 32'h80);
        step();
        check("bl_link_off", {31'd0, bus.link_we}, 32'd0);
        check("bl_still_valid", {31'd0, bus.redirect_valid}, 32'd1);
        drain("bl_drain");

        // br via register; traffic during busy is dropped
        branch(3'b111, 32'h999, 32'hDEADBEEC, 32'h0);
        exp_cnt++;
        check("br_pc", bus.redirect_pc, 32'hDEADBEEC);
        bus.br_valid   = 1'b1;
        bus.br_type    = 3'b000;
        bus.br_target  = 32'h111;
        bus.alu_valid  = 1'b1;
        bus.flag_we    = 1'b1;
        bus.alu_fZero  = 1'b0;
        bus.alu_fSign  = 1'b1;
        bus.alu_fCarry = 1'b1;
        step();
        clear_inputs();
        check("busy_flags_kept", {29'd0, bus.flags}, 32'h1);
        check("busy_pc_kept",    bus.redirect_pc, 32'hDEADBEEC);
        drain("br_drain");
        check("busy_cnt", {28'd0, bus.taken_count}, exp_cnt);
        check("br_pc_after", bus.redirect_pc, 32'hDEADBEEC);

        // same-cycle flag update plus bltz (old S=0)
        bus.alu_valid  = 1'b1;
        bus.flag_we    = 1'b1;
        bus.alu_result = 32'h80000000;
        bus.alu_fZero  = 1'b0;
        bus.alu_fSign  = 1'b1;
        bus.alu_fCarry = 1'b0;
        bus.br_valid   = 1'b1;
        bus.br_type    = 3'b110;
        bus.br_target  = 32'h500;
        step();
        clear_inputs();
        check("bltz_flags", {29'd0, bus.flags}, 32'h2);
`ifdef FLAG_BYPASS_EN
        exp_cnt++;
        check("bltz_byp_valid", {31'd0, bus.redirect_valid}, 32'd1);
        check("bltz_byp_pc",    bus.redirect_pc, 32'h500);
        drain("bltz_drain");
`else
        check("bltz_nobyp_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check("bltz_nobyp_busy",  {31'd0, bus.busy}, 32'd0);
`endif
        check("bltz_cnt", {28'd0, bus.taken_count}, exp_cnt);

        // saturation of the taken counter
        for (int i = 0; i < 13; i++) begin
            branch(3'b000, 32'h600 + 32'(i * 4), 32'h0, 32'h0);
            if (exp_cnt < (1 << CW) - 1) exp_cnt++;
            drain("sat_drain");
            check("sat_cnt", {28'd0, bus.taken_count}, exp_cnt);
        end
        check("sat_final", {28'd0, bus.taken_count}, 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
